// File: rtl/crypto_key_pkg.sv
// Shared types for the crypto key store controller.
//   state_t      controller FSM states (IDLE, GRANT, ZERO)
//   rsp_flags_t  registered response strobe and error flag
//   idx_width()  width of an index into n items, never less than 1 bit
package crypto_key_pkg;

  localparam int KEY_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ZERO  = 2'd2
  } state_t;

  typedef struct packed {
    logic valid;
    logic err;
  } rsp_flags_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/crypto_key_store_ctrl_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request starting at the
// pointer and returns a one-hot grant plus its index. The pointer moves to
// (granted + 1) mod NUM_REQ whenever a grant is issued.
//   clk, resetn   clock, asynchronous active-high reset
//   en            1 = grants allowed this cycle
//   req           per-requester request vector
//   grant         one-hot grant (all zero when en is low or no request)
//   grant_idx     index of the granted requester (pointer value when idle)
module rr_arbiter
  import crypto_key_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             en,
  input  logic [NUM_REQ-1:0]               req,
  output logic [NUM_REQ-1:0]               grant,
  output logic [idx_width(NUM_REQ)-1:0]    grant_idx
);

  localparam int PTR_W = idx_width(NUM_REQ);

  logic [PTR_W-1:0] ptr_q;
  logic             found;
  int               idx;

  // NOTE: combinational blocks use blocking assignments and give every
  // output a default first, so no path through the block can infer a latch.
  always_comb begin
    grant     = '0;
    grant_idx = ptr_q;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      ptr_q <= '0;
    end else if (found) begin
      if (grant_idx == PTR_W'(NUM_REQ - 1)) ptr_q <= '0;
      else                                  ptr_q <= grant_idx + PTR_W'(1);
    end
  end

endmodule

// File: rtl/crypto_key_store_ctrl.sv
// Arbitrated controller for a bank of key slots shared by NUM_REQ requesters.
// One read or write is accepted per cycle (round-robin), writes honour a
// per-slot lock, and a zeroize pulse starts a one-slot-per-cycle sweep that
// clears every key and lock.
//   clk, resetn   clock, asynchronous active-high reset
//   req_valid     per-requester request valid
//   req_write     1 = write, 0 = read
//   req_lock      on write: lock the slot after writing
//   req_slot      packed slot indices, requester i at [i*SLOT_W +: SLOT_W]
//   req_wdata     packed write data,   requester i at [i*KEY_W  +: KEY_W]
//   req_ready     one-hot grant; request accepted when valid & ready
//   rsp_valid     one-cycle response strobe, cycle after accept
//   rsp_id        requester index of the response
//   rsp_rdata     read data; 0 for writes
//   rsp_err       1 = write hit a locked slot and was dropped
//   zeroize       pulse: clear all keys and locks
//   busy          1 while the zeroize sweep runs (NUM_SLOTS cycles)
module crypto_key_store_ctrl
  import crypto_key_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int NUM_SLOTS = 8,
  parameter int KEY_W     = KEY_W_DEF,
  parameter int SLOT_W    = 3
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ-1:0]             req_lock,
  input  logic [NUM_REQ*SLOT_W-1:0]      req_slot,
  input  logic [NUM_REQ*KEY_W-1:0]       req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           rsp_valid,
  output logic [idx_width(NUM_REQ)-1:0]  rsp_id,
  output logic [KEY_W-1:0]               rsp_rdata,
  output logic                           rsp_err,
  input  logic                           zeroize,
  output logic                           busy
);

  localparam int ID_W = idx_width(NUM_REQ);

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   sweep_cnt_q;
  logic                arb_en;
  logic                sweep_en;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                accept;

  logic [SLOT_W-1:0]   sel_slot;
  logic [KEY_W-1:0]    sel_wdata;
  logic                sel_write;
  logic                sel_lock;

  logic [KEY_W-1:0]    keys_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] locks_q;

  rsp_flags_t          rsp_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic [KEY_W-1:0]    rsp_rdata_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (zeroize)         state_d = ZERO;
        else if (|req_valid) state_d = GRANT;
      end
      GRANT: begin
        if (zeroize) state_d = ZERO;
        else         state_d = IDLE;
      end
      ZERO: begin
        if (sweep_cnt_q == SLOT_W'(NUM_SLOTS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Zeroize takes priority over any pending request in the same cycle, and
  // no request is granted while the sweep runs or reset is held.
  always_comb begin
    busy     = (state_q == ZERO);
    sweep_en = (state_q == ZERO);
    arb_en   = !resetn && (state_q != ZERO) && !zeroize;
  end

  // ---------------------------------------------------------- arbitration
  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .resetn    (resetn),
    .en        (arb_en),
    .req       (req_valid),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  always_comb begin
    sel_slot  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    sel_lock  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_slot  = req_slot[i*SLOT_W +: SLOT_W];
        sel_wdata = req_wdata[i*KEY_W +: KEY_W];
        sel_write = req_write[i];
        sel_lock  = req_lock[i];
      end
    end
  end

  // ------------------------------------------------------ key/lock store
  // NOTE: the key array is a register file with an explicit reset rather
  // than an inferred RAM, because no key material may survive reset.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      for (int s = 0; s < NUM_SLOTS; s++) keys_q[s] <= '0;
      locks_q     <= '0;
      sweep_cnt_q <= '0;
    end else begin
      if (sweep_en) begin
        keys_q[sweep_cnt_q]  <= '0;
        locks_q[sweep_cnt_q] <= 1'b0;
        // Wraps back to 0 on the last slot (NUM_SLOTS is a power of 2).
        sweep_cnt_q          <= sweep_cnt_q + SLOT_W'(1);
      end else begin
        sweep_cnt_q <= '0;
        if (accept && sel_write && !locks_q[sel_slot]) begin
          keys_q[sel_slot]  <= sel_wdata;
          locks_q[sel_slot] <= sel_lock;
        end
      end
    end
  end

  // ------------------------------------------------------------ response
  // Reads return the key as stored before this edge; only one access is
  // accepted per cycle, so no same-cycle write can race the read.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      rsp_q       <= '0;
      rsp_id_q    <= '0;
      rsp_rdata_q <= '0;
    end else if (accept) begin
      rsp_q.valid <= 1'b1;
      rsp_q.err   <= sel_write && locks_q[sel_slot];
      rsp_id_q    <= grant_idx;
      rsp_rdata_q <= sel_write ? '0 : keys_q[sel_slot];
    end else begin
      rsp_q       <= '0;
      rsp_id_q    <= '0;
      rsp_rdata_q <= '0;
    end
  end

  assign rsp_valid = rsp_q.valid;
  assign rsp_err   = rsp_q.err;
  assign rsp_id    = rsp_id_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_crypto_key_store_ctrl.sv
// Self-checking bench for crypto_key_store_ctrl: directed scenarios against
// known constants plus a randomized run against a slot-array reference model.
module tb_crypto_key_store_ctrl;

  localparam int NR = 2;
  localparam int NS = 8;
  localparam int KW = 16;
  localparam int SW = 3;

  logic              clk = 1'b0;
  logic              resetn;
  logic [NR-1:0]     req_valid, req_write, req_lock;
  logic [NR*SW-1:0]  req_slot;
  logic [NR*KW-1:0]  req_wdata;
  logic [NR-1:0]     req_ready;
  logic              rsp_valid;
  logic [0:0]        rsp_id;
  logic [KW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              zeroize;
  logic              busy;

  int total = 0;
  int bad   = 0;

  crypto_key_store_ctrl #(
    .NUM_REQ(NR), .NUM_SLOTS(NS), .KEY_W(KW), .SLOT_W(SW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_lock  (req_lock),
    .req_slot  (req_slot),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .zeroize   (zeroize),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------ reference model
  int            m_ptr;
  logic [KW-1:0] m_key [NS];
  bit            m_lock [NS];
  int            m_zleft;   // sweep cycles still to run

  logic [NR-1:0] exp_rdy, obs_rdy;
  logic          exp_busy, obs_busy;
  logic          exp_rv, obs_rv, exp_err, obs_err;
  int            exp_id;
  logic [0:0]    obs_id;
  logic [KW-1:0] exp_rd, obs_rd;

  task automatic model_reset();
    m_ptr   = 0;
    m_zleft = 0;
    for (int s = 0; s < NS; s++) begin
      m_key[s]  = '0;
      m_lock[s] = 1'b0;
    end
  endtask

  // Predicts this cycle's grant/busy and the response that follows it,
  // then advances the model to the state after the clock edge.
  task automatic model_cycle();
    bit done;
    int g, sl;
    exp_rdy  = '0;
    exp_rv   = 1'b0;
    exp_err  = 1'b0;
    exp_id   = 0;
    exp_rd   = '0;
    exp_busy = (m_zleft > 0);
    done     = 1'b0;
    if (m_zleft > 0) begin
      m_key[NS - m_zleft]  = '0;
      m_lock[NS - m_zleft] = 1'b0;
      m_zleft--;
    end else if (zeroize) begin
      m_zleft = NS;
    end else begin
      for (int k = 0; k < NR; k++) begin
        g = (m_ptr + k) % NR;
        if (!done && req_valid[g]) begin
          done       = 1'b1;
          exp_rdy[g] = 1'b1;
          exp_rv     = 1'b1;
          exp_id     = g;
          sl         = int'(req_slot[g*SW +: SW]);
          if (!req_write[g]) begin
            exp_rd = m_key[sl];
          end else if (m_lock[sl]) begin
            exp_err = 1'b1;
          end else begin
            m_key[sl]  = req_wdata[g*KW +: KW];
            m_lock[sl] = req_lock[g];
          end
          m_ptr = (g + 1) % NR;
        end
      end
    end
  endtask

  // One clock: inputs are already set (just after a rising edge).
  task automatic tick();
    model_cycle();
    @(negedge clk);
    obs_rdy  = req_ready;
    obs_busy = busy;
    @(posedge clk);
    #1;
    obs_rv  = rsp_valid;
    obs_id  = rsp_id;
    obs_rd  = rsp_rdata;
    obs_err = rsp_err;
  endtask

  task automatic set_req(input int i, input bit v, input bit w, input bit l,
                         input int slot, input logic [KW-1:0] d);
    req_valid[i]           = v;
    req_write[i]           = w;
    req_lock[i]            = l;
    req_slot[i*SW +: SW]   = SW'(slot);
    req_wdata[i*KW +: KW]  = d;
  endtask

  task automatic clear_reqs();
    req_valid = '0; req_write = '0; req_lock = '0;
    req_slot  = '0; req_wdata = '0; zeroize  = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  // ----------------------------------------------------------- scenarios
  task automatic test_reset();
    clear_reqs();
    req_valid = '1;
    resetn    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({req_ready, rsp_valid, rsp_err, busy, rsp_id, rsp_rdata} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: ready=%b vld=%b err=%b busy=%b id=%h rd=%h, want all 0",
               req_ready, rsp_valid, rsp_err, busy, rsp_id, rsp_rdata);
    end
    clear_reqs();
    release_reset();
  endtask

  task automatic test_read_after_reset();
    set_req(0, 1, 0, 0, 3, '0);
    tick();
    total++;
    if (obs_rdy !== 2'b01) begin
      bad++; $display("FAIL rd3_ready: got %b want 01", obs_rdy);
    end
    total++;
    if ({obs_rv, obs_id, obs_err, obs_rd} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      bad++;
      $display("FAIL rd3_rsp: vld=%b id=%h err=%b rd=%h want 1 0 0 0000",
               obs_rv, obs_id, obs_err, obs_rd);
    end
    clear_reqs();
  endtask

  task automatic test_lock_write();
    set_req(0, 1, 1, 1, 2, 16'hBEEF);
    tick();
    total++;
    if (obs_rv !== 1'b1 || obs_err !== 1'b0) begin
      bad++; $display("FAIL lock_wr1: vld=%b err=%b want 1 0", obs_rv, obs_err);
    end
    set_req(0, 1, 0, 0, 2, '0);
    tick();
    total++;
    if (obs_rd !== 16'hBEEF) begin
      bad++; $display("FAIL lock_rd1: got %h want beef", obs_rd);
    end
    set_req(0, 1, 1, 0, 2, 16'h1234);
    tick();
    total++;
    if (obs_rv !== 1'b1 || obs_err !== 1'b1 || obs_rd !== 16'h0) begin
      bad++;
      $display("FAIL lock_wr2: vld=%b err=%b rd=%h want 1 1 0000", obs_rv, obs_err, obs_rd);
    end
    set_req(0, 1, 0, 0, 2, '0);
    tick();
    total++;
    if (obs_rd !== 16'hBEEF || obs_err !== 1'b0) begin
      bad++; $display("FAIL lock_rd2: rd=%h err=%b want beef 0", obs_rd, obs_err);
    end
    clear_reqs();
  endtask

  task automatic test_alternate();
    logic [NR-1:0] prev;
    set_req(0, 1, 0, 0, 2, '0);
    set_req(1, 1, 0, 0, 0, '0);
    prev = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      total++;
      if (obs_rdy !== exp_rdy || obs_rdy === prev || !obs_rv || obs_id !== 1'(exp_id)) begin
        bad++;
        $display("FAIL alt_c%0d: ready=%b prev=%b vld=%b id=%h want ready=%b id=%0d",
                 c, obs_rdy, prev, obs_rv, obs_id, exp_rdy, exp_id);
      end
      total++;
      if (obs_rd !== (obs_id == 1'b0 ? 16'hBEEF : 16'h0000)) begin
        bad++; $display("FAIL alt_rd_c%0d: got %h", c, obs_rd);
      end
      prev = obs_rdy;
    end
    clear_reqs();
  endtask

  task automatic test_zeroize();
    for (int s = 0; s < NS; s++) begin
      set_req(0, 1, 1, 0, s, 16'hA5A5);
      tick();
    end
    set_req(0, 1, 0, 0, 5, '0);
    tick();
    total++;
    if (obs_rd !== 16'hA5A5) begin
      bad++; $display("FAIL zfill_rd5: got %h want a5a5", obs_rd);
    end
    zeroize = 1'b1;
    set_req(1, 1, 0, 0, 1, '0);
    tick();
    total++;
    if (obs_rdy !== 2'b00 || obs_rv !== 1'b0) begin
      bad++; $display("FAIL z_pulse: ready=%b vld=%b want 00 0", obs_rdy, obs_rv);
    end
    zeroize = 1'b0;
    for (int c = 0; c < NS; c++) begin
      if (c == 3) zeroize = 1'b1;   // ignored mid-sweep
      tick();
      zeroize = 1'b0;
      total++;
      if (obs_busy !== 1'b1 || obs_rdy !== 2'b00 || obs_rv !== 1'b0) begin
        bad++;
        $display("FAIL z_busy_c%0d: busy=%b ready=%b vld=%b want 1 00 0",
                 c, obs_busy, obs_rdy, obs_rv);
      end
    end
    tick();
    total++;
    if (obs_busy !== 1'b0 || obs_rdy !== exp_rdy || obs_rd !== 16'h0 || !obs_rv) begin
      bad++;
      $display("FAIL z_after: busy=%b ready=%b vld=%b rd=%h want 0 %b 1 0000",
               obs_busy, obs_rdy, obs_rv, obs_rd, exp_rdy);
    end
    clear_reqs();
    for (int s = 0; s < NS; s++) begin
      set_req(0, 1, 0, 0, s, '0);
      tick();
      total++;
      if (obs_rd !== 16'h0 || !obs_rv) begin
        bad++; $display("FAIL z_slot%0d: vld=%b rd=%h want 1 0000", s, obs_rv, obs_rd);
      end
    end
    set_req(0, 1, 1, 0, 2, 16'h7777);
    tick();
    set_req(0, 1, 0, 0, 2, '0);
    tick();
    total++;
    if (obs_rd !== 16'h7777) begin
      bad++; $display("FAIL z_unlock2: got %h want 7777", obs_rd);
    end
    clear_reqs();
  endtask

  task automatic test_unlocked_rewrite();
    set_req(1, 1, 1, 0, 4, 16'h1111);
    tick();
    set_req(1, 1, 1, 0, 4, 16'h2222);
    tick();
    total++;
    if (obs_err !== 1'b0 || !obs_rv) begin
      bad++; $display("FAIL rewr_err: vld=%b err=%b want 1 0", obs_rv, obs_err);
    end
    set_req(1, 1, 0, 0, 4, '0);
    tick();
    total++;
    if (obs_rd !== 16'h2222 || obs_id !== 1'b1) begin
      bad++; $display("FAIL rewr_rd: rd=%h id=%h want 2222 1", obs_rd, obs_id);
    end
    clear_reqs();
  endtask

  task automatic test_reset_mid();
    set_req(0, 1, 1, 0, 6, 16'h6666);
    tick();
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    repeat (3) tick();
    #2 resetn = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || req_ready !== '0) begin
      bad++; $display("FAIL rst_sweep: busy=%b ready=%b want 0 00", busy, req_ready);
    end
    release_reset();
    set_req(0, 1, 1, 0, 6, 16'h6666);
    tick();
    set_req(0, 1, 0, 0, 6, '0);
    tick();
    total++;
    if (obs_rv !== 1'b1) begin
      bad++; $display("FAIL rst_pre_grant: vld=%b want 1", obs_rv);
    end
    #2 resetn = 1'b1;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== '0 || req_ready !== '0) begin
      bad++;
      $display("FAIL rst_grant: vld=%b rd=%h ready=%b want 0 0000 00",
               rsp_valid, rsp_rdata, req_ready);
    end
    release_reset();
    tick();
    total++;
    if (obs_rd !== 16'h0 || !obs_rv) begin
      bad++; $display("FAIL rst_keys: vld=%b rd=%h want 1 0000", obs_rv, obs_rd);
    end
    clear_reqs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      zeroize = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
          set_req(i, 1, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, NS - 1)), KW'($urandom));
        end
      end
      tick();
      total++;
      if (obs_rdy !== exp_rdy || obs_busy !== exp_busy || obs_rv !== exp_rv) begin
        bad++;
        $display("FAIL rnd_ctl_c%0d: ready=%b busy=%b vld=%b want %b %b %b",
                 c, obs_rdy, obs_busy, obs_rv, exp_rdy, exp_busy, exp_rv);
      end
      if (exp_rv) begin
        total++;
        if (obs_id !== 1'(exp_id) || obs_err !== exp_err || obs_rd !== exp_rd) begin
          bad++;
          $display("FAIL rnd_rsp_c%0d: id=%h err=%b rd=%h want %0d %b %h",
                   c, obs_id, obs_err, obs_rd, exp_id, exp_err, exp_rd);
        end
      end
      for (int i = 0; i < NR; i++) if (exp_rdy[i]) req_valid[i] = 1'b0;
    end
    clear_reqs();
  endtask

  initial begin
    clear_reqs();
    resetn = 1'b1;
    model_reset();
    test_reset();
    test_read_after_reset();
    test_lock_write();
    test_alternate();
    test_zeroize();
    test_unlocked_rewrite();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
